// File: rtl/zap_wb_write_drain_pkg.sv
// Shared types for the write-buffer drain: queued write entry layout, FSM states
// and the Wishbone cycle-type constant.
package zap_wb_write_drain_pkg;
  localparam int ADR_W   = 32;
  localparam int DAT_W   = 32;
  localparam int SEL_W   = 4;
  localparam int ENTRY_W = ADR_W + DAT_W + SEL_W;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  // Field order matches the FIFO word: adr in [67:36], dat in [35:4], sel in [3:0].
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ERR   = 2'd2
  } drain_state_e;
endpackage

// File: rtl/zap_wb_write_drain.sv
// Pops write entries from a show-ahead FIFO and retires them as Wishbone classic
// single writes, holding CYC across up to MAX_BEATS back-to-back beats.
module zap_wb_write_drain
  import zap_wb_write_drain_pkg::*;
#(
  parameter int MAX_BEATS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [ENTRY_W-1:0] i_fifo_data,
  input  logic               i_fifo_empty,
  output logic               o_fifo_ack,
  input  logic               i_stall,
  output logic               o_wb_cyc,
  output logic               o_wb_stb,
  output logic               o_wb_we,
  output logic [ADR_W-1:0]   o_wb_adr,
  output logic [DAT_W-1:0]   o_wb_dat,
  output logic [SEL_W-1:0]   o_wb_sel,
  output logic [2:0]         o_wb_cti,
  input  logic               i_wb_ack,
  input  logic               i_wb_err,
  output logic               o_idle,
  output logic               o_err,
  output logic [ADR_W-1:0]   o_err_adr,
  input  logic               i_err_clr
);
  localparam int              CNT_W     = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  drain_state_e     state;
  logic [CNT_W-1:0] beat_cnt;
  logic             bus_act;
  wb_entry_t        head, cur;
  logic             err_q;
  logic [ADR_W-1:0] err_adr;
  logic             beat_ok, load;

  assign head    = i_fifo_data;
  assign beat_ok = (state == ST_WRITE) & i_wb_ack & ~i_wb_err;
  // Chaining only on a clean ACK keeps CYC continuous; the last permitted beat forces a drop.
  assign load    = ~i_reset & ~i_fifo_empty & ~i_stall &
                   ((state == ST_IDLE) | (beat_ok & (beat_cnt != LAST_BEAT)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      bus_act  <= 1'b0;
      beat_cnt <= '0;
      cur      <= '0;
      err_q    <= 1'b0;
      err_adr  <= '0;
    end else begin
      if (i_err_clr) err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            cur     <= head;
            bus_act <= 1'b1;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // ERR beats ACK; the faulting entry is dropped, not retried.
          if (i_wb_err) begin
            bus_act  <= 1'b0;
            beat_cnt <= '0;
            err_q    <= 1'b1;
            err_adr  <= cur.adr;
            state    <= ST_ERR;
          end else if (i_wb_ack) begin
            if (load) begin
              cur      <= head;
              beat_cnt <= beat_cnt + CNT_W'(1);
            end else begin
              bus_act  <= 1'b0;
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end
          end
        end
        ST_ERR: begin
          if (i_err_clr) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_fifo_ack = load;
  assign o_wb_cyc   = bus_act;
  assign o_wb_stb   = bus_act;
  assign o_wb_we    = bus_act;
  assign o_wb_adr   = {cur.adr[ADR_W-1:2], 2'b00};
  assign o_wb_dat   = cur.dat;
  assign o_wb_sel   = cur.sel;
  assign o_wb_cti   = CTI_CLASSIC;
  assign o_idle     = (state == ST_IDLE) & i_fifo_empty;
  assign o_err      = err_q;
  assign o_err_adr  = err_adr;
endmodule

// File: doc/zap_wb_write_drain.md
# zap_wb_write_drain

Read-side consumer for the team's synchronous write-buffer FIFO: pops queued write entries from a show-ahead FIFO port and retires them as Wishbone B3 classic single writes. Sits between the write buffer and the external Wishbone master port, holding CYC across back-to-back entries for up to MAX_BEATS beats. Captures bus errors and stalls draining until software clears the error.

## Interface
Parameters:
- MAX_BEATS, 16: maximum consecutive acknowledged beats under one CYC assertion; legal range 1..256.

Ports:
- i_clk  in  1  sole clock; all logic is posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_fifo_data  in  68  FIFO head entry, valid when i_fifo_empty=0: [67:36] address, [35:4] data, [3:0] byte select.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_ack  out  1  pop strobe; combinational.
- i_stall  in  1  when 1, no new entry is loaded; an in-flight beat still completes.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone controls; WE=1 whenever STB=1.
- o_wb_adr  out  32  byte address; bits [1:0] driven 0.
- o_wb_dat  out  32  write data.
- o_wb_sel  out  4  byte select.
- o_wb_cti  out  3  constant 3'b000.
- i_wb_ack, i_wb_err  in  1 each  slave termination.
- o_idle  out  1  combinational: state IDLE and i_fifo_empty=1.
- o_err  out  1  sticky bus-error flag.
- o_err_adr  out  32  address of the beat that received ERR.
- i_err_clr  in  1  clears o_err and leaves ERR state.

## Operation
- States: IDLE, WRITE, ERR.
- load = ~i_fifo_empty & ~i_stall & (IDLE | (WRITE & i_wb_ack & ~i_wb_err & beat_cnt != MAX_BEATS-1)); o_fifo_ack = load.
- On load: address/data/sel registers take the head entry; CYC=STB=1 from the next cycle; state WRITE.
- WRITE, ACK and no ERR: beat_cnt+1; if load, stay WRITE with new entry; else CYC=STB=0 next cycle, beat_cnt=0, state IDLE.
- WRITE, ERR (wins over simultaneous ACK): CYC=STB=0 next cycle, o_err=1, o_err_adr=current address, state ERR; entry is discarded, no retry, no pop.
- ERR: no loads; i_err_clr=1 -> o_err=0, state IDLE next cycle. i_err_clr in IDLE/WRITE only clears o_err.
- beat_cnt width $clog2(MAX_BEATS)+1; cleared whenever CYC drops.
- i_stall asserted during WRITE: current beat completes, then CYC drops.
- Address/data/sel registers hold their value while STB is high and not terminated.

## Timing
- Reset: state IDLE; o_wb_cyc, o_wb_stb, o_wb_we, o_err=0; o_wb_adr, o_wb_dat, o_err_adr=0; o_wb_sel=0; beat_cnt=0. Reset mid-beat drops CYC next cycle without popping; FIFO contents are untouched.
- Load latency: pop at cycle N -> STB high at N+1.
- Back-to-back throughput: 1 beat/cycle with zero-wait ACK; new address visible the cycle after ACK.
- After the MAX_BEATS-th ACK: CYC low for at least one cycle; earliest next pop is the cycle after, with STB high one cycle later.
- MAX_BEATS=1: every beat is its own CYC, with at least one idle cycle between beats.

## Structure
- Shared package: 68-bit write-entry struct (adr, dat, sel) with field widths as named constants; state enum (IDLE, WRITE, ERR); CTI_CLASSIC constant.
- No sub-module; one FSM with beat counter and output registers. The parent instantiates it next to the FIFO.

## Test plan
- Single entry {adr 0x1000, dat 0xDEADBEEF, sel 0xF}, ACK after 2 wait cycles -> one pop, one beat with the exact values, CYC low the cycle after ACK, o_idle=1.
- 20 sequential entries, MAX_BEATS=16, zero-wait ACK -> 16 beats under one CYC, 1-cycle CYC gap, 4 beats under a second CYC, 20 pops total, data order preserved.
- ERR on the 3rd of 5 entries (adr 0x2008) -> CYC drops, o_err=1, o_err_adr=0x2008, remaining 2 entries not popped until i_err_clr, then drained normally.
- ACK and ERR asserted in the same cycle -> treated as error; no further pop that cycle.
- i_stall raised while a beat waits for ACK, FIFO non-empty -> beat completes, CYC drops, no pop until i_stall falls.
- i_reset pulsed while STB is high and awaiting ACK -> all outputs at reset values next cycle, o_fifo_ack=0, entry count unchanged.
